// File: rtl/gemm_cmd_ctrl.sv
// rtl/gemm_cmd_ctrl.sv - GEMM command queue and accelerator handshake controller (optional watchdog: GEMM_CMD_WATCHDOG_EN)
module gemm_cmd_ctrl #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gemm_valid,
    input  logic [31:0]                gemm_rdata1,
    input  logic [31:0]                gemm_rdata2,
    output logic                       gemm_done,
    output logic                       acc_start,
    output logic [31:0]                acc_op_a,
    output logic [31:0]                acc_op_b,
    input  logic                       acc_ready,
    input  logic                       acc_finish,
    output logic [$clog2(DEPTH):0]     cmd_count,
    output logic                       q_ovf,
    output logic                       gemm_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [63:0]    head;
    logic           full, push, pop, wd_expire;

    assign full = (cmd_count == CW'(DEPTH));
    assign push = gemm_valid && !full;
    assign pop  = (state == ISSUE) && acc_ready;
    assign head = mem[rd_ptr];

    // Operands come straight from the queue head, which cannot move until the pop
    assign acc_start = (state == ISSUE);
    assign acc_op_a  = (state == ISSUE) ? head[63:32] : 32'd0;
    assign acc_op_b  = (state == ISSUE) ? head[31:0]  : 32'd0;
    assign gemm_done = (state == DONE);

    // Command storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {gemm_rdata1, gemm_rdata2};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // Sticky overflow flag: a command was dropped because the queue was full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_ovf <= 1'b0;
        end else if (gemm_valid && full) begin
            q_ovf <= 1'b1;
        end
    end

`ifdef GEMM_CMD_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    assign wd_expire = (state == BUSY) && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent in BUSY, restarting from zero on every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state != BUSY) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky error: the accelerator never finished within the watchdog limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gemm_err <= 1'b0;
        end else if (wd_expire && !acc_finish) begin
            gemm_err <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign gemm_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; an incoming push counts so the first issue follows its capture directly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_count != '0 || push) state_nxt = ISSUE;
            ISSUE:   if (acc_ready) state_nxt = BUSY;
            BUSY:    if (acc_finish || wd_expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gemm_cmd_ctrl.sv
// tb/tb_gemm_cmd_ctrl.sv - self-checking bench for gemm_cmd_ctrl
module tb_gemm_cmd_ctrl;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gemm_valid = 1'b0;
    logic [31:0] gemm_rdata1 = '0;
    logic [31:0] gemm_rdata2 = '0;
    logic        gemm_done;
    logic        acc_start;
    logic [31:0] acc_op_a;
    logic [31:0] acc_op_b;
    logic        acc_ready = 1'b0;
    logic        acc_finish = 1'b0;
    logic [2:0]  cmd_count;
    logic        q_ovf;
    logic        gemm_err;

    int errors = 0;
    int checks = 0;

    gemm_cmd_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .gemm_valid(gemm_valid),
        .gemm_rdata1(gemm_rdata1), .gemm_rdata2(gemm_rdata2),
        .gemm_done(gemm_done), .acc_start(acc_start),
        .acc_op_a(acc_op_a), .acc_op_b(acc_op_b),
        .acc_ready(acc_ready), .acc_finish(acc_finish),
        .cmd_count(cmd_count), .q_ovf(q_ovf), .gemm_err(gemm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdy;
        logic        fin;
        logic        e_start;
        logic        e_done;
        logic [2:0]  e_cnt;
        logic [31:0] e_opa;
        logic [31:0] e_opb;
    } vec_t;

    vec_t vecs [17];

    // Reference model state: queue of accepted commands plus handshake phase flags
    logic [63:0] mq [$];
    bit m_offer, m_wait, m_done, m_ovf, m_err;
    int m_wcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gemm_valid = 1'b0; acc_ready = 1'b0; acc_finish = 1'b0;
        step();
        rst = 1'b0;
        mq.delete();
        m_offer = 0; m_wait = 0; m_done = 0; m_ovf = 0; m_err = 0; m_wcnt = 0;
    endtask

    task automatic push_in(input logic [31:0] a, input logic [31:0] b);
        gemm_valid = 1'b1; gemm_rdata1 = a; gemm_rdata2 = b;
    endtask

    // Expects a command currently offered; accepts it, finishes it and returns to IDLE+1
    task automatic run_cmd(input logic [31:0] ea, input logic [31:0] eb);
        chk("ovf_start", {31'd0, acc_start}, 32'd1);
        chk("ovf_op_a", acc_op_a, ea);
        chk("ovf_op_b", acc_op_b, eb);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0; acc_finish = 1'b1;
        step();
        acc_finish = 1'b0;
        chk("ovf_done", {31'd0, gemm_done}, 32'd1);
        step();
        chk("ovf_idle_start", {31'd0, acc_start}, 32'd0);
        step();
    endtask

    // Advance the model by one clock edge given the inputs being driven this cycle
    task automatic model_edge(input bit v, input logic [31:0] a, input logic [31:0] b,
                              input bit rdy, input bit fin);
        bit full, pushed, was_idle;
        int old_sz;
        old_sz   = mq.size();
        full     = (old_sz == DEPTH);
        pushed   = v && !full;
        was_idle = !m_offer && !m_wait && !m_done;
        if (v && full) m_ovf = 1;
        if (m_offer && rdy) void'(mq.pop_front());
        if (pushed) mq.push_back({a, b});
        if (m_done) begin
            m_done = 0;
        end else if (m_wait) begin
            if (fin) begin
                m_wait = 0; m_done = 1;
            end else begin
`ifdef GEMM_CMD_WATCHDOG_EN
                if (m_wcnt == TO - 1) begin
                    m_wait = 0; m_done = 1; m_err = 1;
                end
`endif
                m_wcnt++;
            end
        end else if (m_offer) begin
            if (rdy) begin
                m_offer = 0; m_wait = 1; m_wcnt = 0;
            end
        end else if (was_idle && (old_sz != 0 || pushed)) begin
            m_offer = 1;
        end
    endtask

    initial begin
        // Directed table: single command with immediate ready, then stalled ready
        vecs[0]  = '{1, 32'h1000, 32'h2000, 1, 0,  0, 0, 3'd0, 32'h0, 32'h0};
        vecs[1]  = '{0, 32'h0, 32'h0, 1, 0,       1, 0, 3'd1, 32'h1000, 32'h2000};
        vecs[2]  = '{0, 32'h0, 32'h0, 0, 0,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[3]  = '{0, 32'h0, 32'h0, 0, 0,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[4]  = '{0, 32'h0, 32'h0, 0, 1,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[5]  = '{0, 32'h0, 32'h0, 0, 0,       0, 1, 3'd0, 32'h0, 32'h0};
        vecs[6]  = '{0, 32'h0, 32'h0, 0, 0,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[7]  = '{1, 32'hAAAA0001, 32'h55550002, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0};
        vecs[8]  = '{0, 32'h0, 32'h0, 0, 1,       1, 0, 3'd1, 32'hAAAA0001, 32'h55550002};
        vecs[9]  = '{0, 32'h0, 32'h0, 0, 0,       1, 0, 3'd1, 32'hAAAA0001, 32'h55550002};
        vecs[10] = '{0, 32'h0, 32'h0, 0, 0,       1, 0, 3'd1, 32'hAAAA0001, 32'h55550002};
        vecs[11] = '{0, 32'h0, 32'h0, 1, 0,       1, 0, 3'd1, 32'hAAAA0001, 32'h55550002};
        vecs[12] = '{0, 32'h0, 32'h0, 0, 0,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[13] = '{0, 32'h0, 32'h0, 0, 1,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[14] = '{0, 32'h0, 32'h0, 0, 0,       0, 1, 3'd0, 32'h0, 32'h0};
        vecs[15] = '{0, 32'h0, 32'h0, 0, 1,       0, 0, 3'd0, 32'h0, 32'h0};
        vecs[16] = '{0, 32'h0, 32'h0, 0, 0,       0, 0, 3'd0, 32'h0, 32'h0};

        step();
        chk("reset_start", {31'd0, acc_start}, 32'd0);
        chk("reset_done", {31'd0, gemm_done}, 32'd0);
        chk("reset_count", {29'd0, cmd_count}, 32'd0);
        chk("reset_ovf", {31'd0, q_ovf}, 32'd0);
        chk("reset_err", {31'd0, gemm_err}, 32'd0);
        chk("reset_op_a", acc_op_a, 32'd0);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            gemm_valid = vecs[i].v; gemm_rdata1 = vecs[i].a; gemm_rdata2 = vecs[i].b;
            acc_ready = vecs[i].rdy; acc_finish = vecs[i].fin;
            chk($sformatf("vec%0d_start", i), {31'd0, acc_start}, {31'd0, vecs[i].e_start});
            chk($sformatf("vec%0d_done", i), {31'd0, gemm_done}, {31'd0, vecs[i].e_done});
            chk($sformatf("vec%0d_count", i), {29'd0, cmd_count}, {29'd0, vecs[i].e_cnt});
            if (vecs[i].e_start) begin
                chk($sformatf("vec%0d_op_a", i), acc_op_a, vecs[i].e_opa);
                chk($sformatf("vec%0d_op_b", i), acc_op_b, vecs[i].e_opb);
            end
            step();
        end
        gemm_valid = 1'b0; acc_ready = 1'b0; acc_finish = 1'b0;

        // Overflow: five back-to-back pushes with ready low
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_in(32'h100 + k, 32'h200 + k);
            step();
        end
        gemm_valid = 1'b0;
        chk("ovf_count", {29'd0, cmd_count}, 32'd4);
        chk("ovf_flag", {31'd0, q_ovf}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            run_cmd(32'h100 + k, 32'h200 + k);
        end
        chk("ovf_drain_count", {29'd0, cmd_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("ovf_no_fifth", {31'd0, acc_start}, 32'd0);
            step();
        end
        chk("ovf_sticky", {31'd0, q_ovf}, 32'd1);

        // Simultaneous push and pop at occupancy two
        do_reset();
        push_in(32'h11, 32'h12); step();
        push_in(32'h21, 32'h22); step();
        gemm_valid = 1'b0;
        chk("pp_count_before", {29'd0, cmd_count}, 32'd2);
        push_in(32'h31, 32'h32); acc_ready = 1'b1;
        step();
        gemm_valid = 1'b0; acc_ready = 1'b0;
        chk("pp_count_after", {29'd0, cmd_count}, 32'd2);
        chk("pp_busy_start", {31'd0, acc_start}, 32'd0);

        // Reset while BUSY with a command still queued
        do_reset();
        push_in(32'h77, 32'h88); step();
        push_in(32'h99, 32'hAA); acc_ready = 1'b1; step();
        gemm_valid = 1'b0; acc_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_busy_count", {29'd0, cmd_count}, 32'd0);
        chk("rst_busy_start", {31'd0, acc_start}, 32'd0);
        chk("rst_busy_done", {31'd0, gemm_done}, 32'd0);
        chk("rst_busy_op_a", acc_op_a, 32'd0);
        chk("rst_busy_op_b", acc_op_b, 32'd0);
        chk("rst_busy_err", {31'd0, gemm_err}, 32'd0);
        step();
        rst = 1'b0;
        acc_finish = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_no_done", {31'd0, gemm_done}, 32'd0);
            chk("rst_no_start", {31'd0, acc_start}, 32'd0);
            step();
        end
        acc_finish = 1'b0;

        // Watchdog behaviour: one command, accelerator never finishes
        do_reset();
        push_in(32'hC0DE, 32'hBEEF); step();
        gemm_valid = 1'b0; acc_ready = 1'b1; step();
        acc_ready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            chk("wd_busy_no_done", {31'd0, gemm_done}, 32'd0);
            step();
        end
`ifdef GEMM_CMD_WATCHDOG_EN
        chk("wd_done_pulse", {31'd0, gemm_done}, 32'd1);
        chk("wd_err", {31'd0, gemm_err}, 32'd1);
        step();
        chk("wd_done_once", {31'd0, gemm_done}, 32'd0);
        chk("wd_err_sticky", {31'd0, gemm_err}, 32'd1);
`else
        for (int k = 0; k < 12; k++) begin
            chk("nowd_wait", {31'd0, gemm_done}, 32'd0);
            step();
        end
        chk("nowd_err", {31'd0, gemm_err}, 32'd0);
        acc_finish = 1'b1; step();
        acc_finish = 1'b0;
        chk("nowd_done", {31'd0, gemm_done}, 32'd1);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bit v, rdy, fin;
            logic [31:0] a, b;
            chk("rnd_start", {31'd0, acc_start}, {31'd0, m_offer});
            chk("rnd_done", {31'd0, gemm_done}, {31'd0, m_done});
            chk("rnd_count", {29'd0, cmd_count}, mq.size());
            chk("rnd_ovf", {31'd0, q_ovf}, {31'd0, m_ovf});
            chk("rnd_err", {31'd0, gemm_err}, {31'd0, m_err});
            if (m_offer) begin
                chk("rnd_op_a", acc_op_a, mq[0][63:32]);
                chk("rnd_op_b", acc_op_b, mq[0][31:0]);
            end
            v   = ($urandom_range(0, 99) < 45);
            rdy = ($urandom_range(0, 99) < 50);
            fin = ($urandom_range(0, 99) < 25);
            a   = $urandom;
            b   = $urandom;
            gemm_valid = v; gemm_rdata1 = a; gemm_rdata2 = b;
            acc_ready = rdy; acc_finish = fin;
            model_edge(v, a, b, rdy, fin);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gemm_cmd_ctrl.md
GEMM_CMD_CTRL -- requirements
Module: gemm_cmd_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command-queue entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning BUSY-state watchdog limit in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port gemm_valid  input  1  core issues a GEMM command this cycle.
REQ-006 SHALL have port gemm_rdata1  input  32  command operand A (source base/descriptor).
REQ-007 SHALL have port gemm_rdata2  input  32  command operand B (destination/config).
REQ-008 SHALL have port gemm_done  output  1  one-cycle completion pulse back to core.
REQ-009 SHALL have port acc_start  output  1  command presented to accelerator.
REQ-010 SHALL have port acc_op_a  output  32  operand A of the presented command.
REQ-011 SHALL have port acc_op_b  output  32  operand B of the presented command.
REQ-012 SHALL have port acc_ready  input  1  accelerator accepts the presented command.
REQ-013 SHALL have port acc_finish  input  1  accelerator completed the accepted command.
REQ-014 SHALL have port cmd_count  output  $clog2(DEPTH)+1  queued-command occupancy.
REQ-015 SHALL have port q_ovf  output  1  sticky: command arrived while queue full.
REQ-016 SHALL have port gemm_err  output  1  sticky: watchdog expired.

Function
REQ-017 SHALL push {gemm_rdata1, gemm_rdata2} into a FIFO on each rising edge with gemm_valid=1 and queue not full.
REQ-018 SHALL drop a command arriving with queue full (cmd_count==DEPTH), leave contents unchanged, and set q_ovf.
REQ-019 SHALL implement FSM states IDLE, ISSUE, BUSY, DONE; reset state IDLE.
REQ-020 SHALL transition IDLE->ISSUE on the edge where cmd_count!=0; the earliest acc_start is the cycle after capture.
REQ-021 SHALL in ISSUE drive acc_start=1 with acc_op_a/acc_op_b = FIFO head, held stable until acc_ready=1 is sampled.
REQ-022 SHALL on ISSUE with acc_ready=1 pop the head and enter BUSY; acc_start=0 in all other states.
REQ-023 SHALL in BUSY wait for acc_finish=1, then enter DONE; acc_finish outside BUSY SHALL be ignored.
REQ-024 SHALL assert gemm_done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL on a simultaneous push and pop keep cmd_count unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-026 SHALL accept pushes in every FSM state, including DONE and BUSY.

Reset
REQ-027 SHALL on rst=1 immediately clear FSM to IDLE, FIFO pointers and cmd_count to 0, and gemm_done, acc_start, q_ovf, gemm_err, watchdog counter to 0; acc_op_a/acc_op_b to 0.
REQ-028 SHALL on reset mid-command discard queued and in-flight commands without emitting gemm_done.
REQ-029 SHALL clear q_ovf and gemm_err only by reset.

Configuration
REQ-030 SHALL compile the BUSY watchdog only when macro GEMM_CMD_WATCHDOG_EN is defined.
REQ-031 SHALL with GEMM_CMD_WATCHDOG_EN: count BUSY cycles from 0, reset on BUSY entry; on reaching TIMEOUT_CYCLES without acc_finish, enter DONE (gemm_done pulse) and set gemm_err.
REQ-032 SHALL without GEMM_CMD_WATCHDOG_EN: no counter, BUSY waits indefinitely, gemm_err tied 0.

Verification
REQ-033 SHALL cover: push A=0x1000,B=0x2000 at cycle 0, acc_ready=1 -> acc_start cycle 1 with ops 0x1000/0x2000; acc_finish cycle 4 -> gemm_done only cycle 5.
REQ-034 SHALL cover: acc_ready low 3 cycles in ISSUE -> acc_start and operands held stable 4 cycles, pop on ready.
REQ-035 SHALL cover: DEPTH=4, 5 back-to-back pushes, acc_ready=0 -> cmd_count=4, q_ovf=1, fifth command never issued; the 4 issue in order.
REQ-036 SHALL cover: push coincident with pop at cmd_count=2 -> cmd_count stays 2.
REQ-037 SHALL cover: with GEMM_CMD_WATCHDOG_EN, TIMEOUT_CYCLES=8, acc_finish never -> gemm_done pulse after 8 BUSY cycles, gemm_err=1; rst asserted in BUSY -> all outputs 0, no gemm_done.
